// File: rtl/psk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : psk_pkg
// Description : Shared encodings, phase lookups and state type for the PSK
//               symbol mapper.
// Revision    : 1.0 - initial release
// ============================================================================
package psk_pkg;

    localparam logic IS_BPSK     = 1'b1;
    localparam int   AMP_DEFAULT = 23170;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HOLD     = 2'd1,
        ST_UNDERRUN = 2'd2
    } psk_state_t;

    // QPSK uses a Gray dibit so adjacent phases differ by one bit
    function automatic logic [1:0] phase_inc(input logic is_bpsk, input logic [1:0] bits);
        logic [1:0] inc;
        if (is_bpsk == IS_BPSK) begin
            inc = bits[0] ? 2'd2 : 2'd0;
        end else begin
            case (bits)
                2'b00:   inc = 2'd0;
                2'b01:   inc = 2'd1;
                2'b11:   inc = 2'd2;
                default: inc = 2'd3;
            endcase
        end
        return inc;
    endfunction

    // Returns {i_negative, q_negative}
    function automatic logic [1:0] phase_signs(input logic [1:0] phase);
        logic [1:0] signs;
        case (phase)
            2'd0:    signs = 2'b00;
            2'd1:    signs = 2'b10;
            2'd2:    signs = 2'b11;
            default: signs = 2'b01;
        endcase
        return signs;
    endfunction

endpackage
`default_nettype wire

// File: rtl/psk_diff_encoder.sv
`default_nettype none
// ============================================================================
// Module      : psk_diff_encoder
// Description : 2-bit differential phase accumulator with clear and enable.
// Revision    : 1.0 - initial release
// ============================================================================
module psk_diff_encoder
    import psk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_is_bpsk,
    input  logic [1:0] i_bits,
    output logic [1:0] o_phase,
    output logic [1:0] o_phase_next
);

    logic [1:0] r_phase;

    // A clear in the same cycle as an enable references the symbol to phase 0
    assign o_phase_next = (i_clear ? 2'd0 : r_phase) + phase_inc(i_is_bpsk, i_bits);
    assign o_phase      = r_phase;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= 2'd0;
        end else if (i_enable) begin
            r_phase <= o_phase_next;
        end else if (i_clear) begin
            r_phase <= 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/psk_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module      : psk_symbol_mapper
// Description : Differential BPSK/QPSK mapper holding each I/Q point for SPS
//               output samples on an AXIS stream.
// Revision    : 1.0 - initial release
// ============================================================================
module psk_symbol_mapper
    import psk_pkg::*;
#(
    parameter int BYTES      = 1,
    parameter int SPS        = 4,
    parameter int IQ_W       = 16,
    parameter int AMP        = AMP_DEFAULT,
    parameter int ZERO_STUFF = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [BYTES*8-1:0]   in_tdata,
    input  logic                 in_tvalid,
    output logic                 in_tready,
    input  logic                 in_tlast,
    input  logic                 in_tuser,
    output logic [2*IQ_W-1:0]    out_tdata,
    output logic                 out_tvalid,
    input  logic                 out_tready,
    output logic                 out_tlast,
    output logic                 out_tuser,
    output logic                 pkt_active
);

    localparam int                     c_cnt_w    = (SPS > 1) ? $clog2(SPS) : 1;
    localparam logic [c_cnt_w-1:0]     c_last_cnt = c_cnt_w'(SPS - 1);
    localparam logic signed [IQ_W-1:0] c_amp_pos  = IQ_W'(AMP);
    localparam logic signed [IQ_W-1:0] c_amp_neg  = -c_amp_pos;

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    psk_state_t          r_state;
    psk_state_t          w_state_next;
    logic [c_cnt_w-1:0]  r_cnt;
    logic                r_last;
    logic                r_user;
    logic                r_pkt;
    logic [2*IQ_W-1:0]   r_point;
    logic [2*IQ_W-1:0]   w_point;
    logic [1:0]          w_phase;
    logic [1:0]          w_phase_next;
    logic [1:0]          w_signs;
    logic                w_valid;
    logic                w_cnt_last;
    logic                w_xfer;
    logic                w_last_xfer;
    logic                w_accept;
    logic                w_end_pkt;
    logic                w_restart;
    logic                w_unused;

    // Reset asserts immediately but releases two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end
    assign w_rst_n = r_rst_sync[1];

    assign w_valid     = (r_state == ST_HOLD);
    assign w_cnt_last  = (r_cnt == c_last_cnt);
    assign w_xfer      = w_valid && out_tready;
    assign w_last_xfer = w_xfer && w_cnt_last;
    assign in_tready   = !w_valid || w_last_xfer;
    assign w_accept    = in_tvalid && in_tready;
    assign w_end_pkt   = w_last_xfer && r_last;
    assign w_restart   = (r_state == ST_IDLE) || w_end_pkt;

    psk_diff_encoder u_diff_encoder (
        .clk          (clk),
        .rst_n        (w_rst_n),
        .i_clear      (w_restart),
        .i_enable     (w_accept),
        .i_is_bpsk    (in_tuser),
        .i_bits       (in_tdata[1:0]),
        .o_phase      (w_phase),
        .o_phase_next (w_phase_next)
    );

    assign w_signs = phase_signs(w_phase_next);
    assign w_point = {w_signs[0] ? c_amp_neg : c_amp_pos,
                      w_signs[1] ? c_amp_neg : c_amp_pos};

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_HOLD: begin
                if (w_last_xfer) begin
                    if (w_accept)    w_state_next = ST_HOLD;
                    else if (r_last) w_state_next = ST_IDLE;
                    else             w_state_next = ST_UNDERRUN;
                end
            end
            default: begin
                if (w_accept) w_state_next = ST_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_user  <= IS_BPSK;
            r_pkt   <= 1'b0;
            r_point <= '0;
        end else begin
            if (w_xfer) begin
                r_cnt <= w_cnt_last ? '0 : r_cnt + c_cnt_w'(1);
            end
            if (w_accept) begin
                r_point <= w_point;
                r_last  <= in_tlast;
                r_user  <= in_tuser;
            end
            if (w_accept) begin
                r_pkt <= 1'b1;
            end else if (w_end_pkt) begin
                r_pkt <= 1'b0;
            end
        end
    end

    assign out_tvalid = w_valid;
    assign out_tlast  = r_last && w_cnt_last && w_valid;
    assign out_tuser  = r_user;
    assign pkt_active = r_pkt;
    assign out_tdata  = ((ZERO_STUFF != 0) && (r_cnt != '0)) ? '0 : r_point;

    assign w_unused = &{1'b0, in_tdata[BYTES*8-1:2], w_phase};

endmodule
`default_nettype wire

// File: tb/tb_psk_symbol_mapper.sv
`default_nettype none
// ============================================================================
// Module      : tb_psk_symbol_mapper
// Description : Directed self-checking bench for psk_symbol_mapper (SPS=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_psk_symbol_mapper;

    localparam logic [31:0] PT0 = 32'h5A82_5A82;  // (+A,+A)
    localparam logic [31:0] PT1 = 32'h5A82_A57E;  // (-A,+A)
    localparam logic [31:0] PT2 = 32'hA57E_A57E;  // (-A,-A)
    localparam logic [31:0] PT3 = 32'hA57E_5A82;  // (+A,-A)

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_tdata;
    logic        in_tvalid;
    logic        in_tready;
    logic        in_tlast;
    logic        in_tuser;
    logic [31:0] out_tdata;
    logic        out_tvalid;
    logic        out_tready;
    logic        out_tlast;
    logic        out_tuser;
    logic        pkt_active;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    psk_symbol_mapper #(
        .BYTES(1), .SPS(4), .IQ_W(16), .AMP(23170), .ZERO_STUFF(0)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .in_tlast(in_tlast), .in_tuser(in_tuser),
        .out_tdata(out_tdata), .out_tvalid(out_tvalid), .out_tready(out_tready),
        .out_tlast(out_tlast), .out_tuser(out_tuser), .pkt_active(pkt_active)
    );

    task automatic idle_inputs();
        in_tvalid  = 1'b0;
        in_tdata   = 8'd0;
        in_tlast   = 1'b0;
        in_tuser   = 1'b1;
        out_tready = 1'b1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (in_tready !== 1'b1)   begin fails++; $display("FAIL reset_in_tready got %b want 1", in_tready); end
        tests++; if (out_tvalid !== 1'b0)  begin fails++; $display("FAIL reset_out_tvalid got %b want 0", out_tvalid); end
        tests++; if (out_tdata !== 32'h0)  begin fails++; $display("FAIL reset_out_tdata got %h want 0", out_tdata); end
        tests++; if (out_tuser !== 1'b1)   begin fails++; $display("FAIL reset_out_tuser got %b want 1", out_tuser); end
        tests++; if (out_tlast !== 1'b0)   begin fails++; $display("FAIL reset_out_tlast got %b want 0", out_tlast); end
        tests++; if (pkt_active !== 1'b0)  begin fails++; $display("FAIL reset_pkt_active got %b want 0", pkt_active); end
    endtask

    task automatic test_bpsk();
        logic [7:0]  d [3];
        logic [31:0] e [3];
        int idx = 0;
        int ns  = 0;
        bit acc;
        d = '{8'd0, 8'd1, 8'd1};
        e = '{PT0, PT2, PT0};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_tready = 1'b1;
            in_tuser   = 1'b1;
            in_tvalid  = (idx < 3);
            in_tdata   = 8'd0;
            in_tlast   = 1'b0;
            if (idx < 3) begin
                in_tdata = d[idx];
                in_tlast = (idx == 2);
            end
            #1;
            if (out_tvalid) begin
                ns++;
                tests++; if (out_tdata !== e[(ns-1)/4]) begin fails++; $display("FAIL bpsk_data sample %0d got %h want %h", ns, out_tdata, e[(ns-1)/4]); end
                tests++; if (out_tlast !== (ns == 12))  begin fails++; $display("FAIL bpsk_tlast sample %0d got %b want %b", ns, out_tlast, ns == 12); end
                tests++; if (in_tready !== (ns % 4 == 0)) begin fails++; $display("FAIL bpsk_in_tready sample %0d got %b want %b", ns, in_tready, ns % 4 == 0); end
                tests++; if (out_tuser !== 1'b1)        begin fails++; $display("FAIL bpsk_tuser sample %0d got %b want 1", ns, out_tuser); end
            end else if (c > 0 && ns < 12) begin
                tests++; fails++; $display("FAIL bpsk_bubble cycle %0d got out_tvalid 0 want 1", c);
            end
            acc = in_tvalid && in_tready;
            @(posedge clk);
            if (acc) idx++;
        end
        @(negedge clk); #1;
        tests++; if (ns !== 12)          begin fails++; $display("FAIL bpsk_count got %0d want 12", ns); end
        tests++; if (pkt_active !== 1'b0) begin fails++; $display("FAIL bpsk_pkt_end got %b want 0", pkt_active); end
    endtask

    task automatic test_qpsk();
        logic [7:0]  d [3];
        logic [31:0] e [3];
        int idx = 0;
        int ns  = 0;
        bit acc;
        d = '{8'd1, 8'd3, 8'd2};
        e = '{PT1, PT3, PT2};
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            out_tready = 1'b1;
            in_tuser   = 1'b0;
            in_tvalid  = (idx < 3);
            in_tdata   = 8'd0;
            in_tlast   = 1'b0;
            if (idx < 3) begin
                in_tdata = d[idx];
                in_tlast = (idx == 2);
            end
            #1;
            if (out_tvalid) begin
                ns++;
                tests++; if (out_tdata !== e[(ns-1)/4]) begin fails++; $display("FAIL qpsk_data sample %0d got %h want %h", ns, out_tdata, e[(ns-1)/4]); end
                tests++; if (out_tlast !== (ns == 12))  begin fails++; $display("FAIL qpsk_tlast sample %0d got %b want %b", ns, out_tlast, ns == 12); end
                tests++; if (out_tuser !== 1'b0)        begin fails++; $display("FAIL qpsk_tuser sample %0d got %b want 0", ns, out_tuser); end
            end else if (c > 0 && ns < 12) begin
                tests++; fails++; $display("FAIL qpsk_bubble cycle %0d got out_tvalid 0 want 1", c);
            end
            acc = in_tvalid && in_tready;
            @(posedge clk);
            if (acc) idx++;
        end
        tests++; if (ns !== 12) begin fails++; $display("FAIL qpsk_count got %0d want 12", ns); end
    endtask

    task automatic test_backpressure();
        int xfer  = 0;
        int stall = 0;
        bit sent  = 1'b0;
        bit acc;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            in_tvalid  = !sent;
            in_tdata   = 8'd1;
            in_tlast   = 1'b1;
            in_tuser   = 1'b1;
            out_tready = !(xfer == 1 && stall < 3);
            #1;
            if (out_tvalid) begin
                tests++; if (out_tdata !== PT2) begin fails++; $display("FAIL bp_data cycle %0d got %h want %h", c, out_tdata, PT2); end
                if (!out_tready) begin
                    stall++;
                    tests++; if (in_tready !== 1'b0) begin fails++; $display("FAIL bp_in_tready stall %0d got %b want 0", stall, in_tready); end
                    tests++; if (out_tlast !== 1'b0) begin fails++; $display("FAIL bp_tlast stall %0d got %b want 0", stall, out_tlast); end
                end else begin
                    xfer++;
                    tests++; if (out_tlast !== (xfer == 4)) begin fails++; $display("FAIL bp_tlast xfer %0d got %b want %b", xfer, out_tlast, xfer == 4); end
                end
            end
            acc = in_tvalid && in_tready;
            @(posedge clk);
            if (acc) sent = 1'b1;
        end
        tests++; if (xfer !== 4)  begin fails++; $display("FAIL bp_xfer_count got %0d want 4", xfer); end
        tests++; if (stall !== 3) begin fails++; $display("FAIL bp_stall_count got %0d want 3", stall); end
    endtask

    task automatic test_underrun();
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            out_tready = 1'b1;
            in_tuser   = 1'b1;
            in_tdata   = 8'd1;
            in_tvalid  = (c == 0 || c == 9);
            in_tlast   = (c == 9);
            #1;
            if (c >= 1 && c <= 4) begin
                tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT2) begin fails++; $display("FAIL ur_first cycle %0d got v=%b %h want v=1 %h", c, out_tvalid, out_tdata, PT2); end
            end else if (c >= 5 && c <= 9) begin
                tests++; if (out_tvalid !== 1'b0) begin fails++; $display("FAIL ur_gap_valid cycle %0d got %b want 0", c, out_tvalid); end
                tests++; if (pkt_active !== 1'b1) begin fails++; $display("FAIL ur_gap_pkt cycle %0d got %b want 1", c, pkt_active); end
            end else if (c >= 10 && c <= 13) begin
                tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT0) begin fails++; $display("FAIL ur_second cycle %0d got v=%b %h want v=1 %h", c, out_tvalid, out_tdata, PT0); end
                tests++; if (out_tlast !== (c == 13)) begin fails++; $display("FAIL ur_tlast cycle %0d got %b want %b", c, out_tlast, c == 13); end
            end else if (c == 14) begin
                tests++; if (out_tvalid !== 1'b0 || pkt_active !== 1'b0) begin fails++; $display("FAIL ur_end got v=%b pkt=%b want 0 0", out_tvalid, pkt_active); end
            end
        end
    endtask

    task automatic test_pkt_boundary();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            out_tready = 1'b1;
            in_tuser   = 1'b1;
            in_tvalid  = (c <= 4);
            in_tdata   = (c == 0) ? 8'd1 : 8'd0;
            in_tlast   = 1'b1;
            #1;
            if (c >= 1 && c <= 4) begin
                tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT2) begin fails++; $display("FAIL pb_pkt_a cycle %0d got v=%b %h want v=1 %h", c, out_tvalid, out_tdata, PT2); end
                tests++; if (out_tlast !== (c == 4)) begin fails++; $display("FAIL pb_tlast_a cycle %0d got %b want %b", c, out_tlast, c == 4); end
            end else if (c >= 5 && c <= 8) begin
                tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT0) begin fails++; $display("FAIL pb_pkt_b cycle %0d got v=%b %h want v=1 %h", c, out_tvalid, out_tdata, PT0); end
                tests++; if (out_tlast !== (c == 8)) begin fails++; $display("FAIL pb_tlast_b cycle %0d got %b want %b", c, out_tlast, c == 8); end
                tests++; if (pkt_active !== 1'b1) begin fails++; $display("FAIL pb_pkt_active cycle %0d got %b want 1", c, pkt_active); end
            end else if (c == 9) begin
                tests++; if (out_tvalid !== 1'b0 || pkt_active !== 1'b0) begin fails++; $display("FAIL pb_end got v=%b pkt=%b want 0 0", out_tvalid, pkt_active); end
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        out_tready = 1'b1;
        in_tuser   = 1'b0;
        in_tdata   = 8'd1;
        in_tlast   = 1'b1;
        in_tvalid  = 1'b1;
        @(negedge clk);
        in_tvalid = 1'b0;
        #1;
        tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT1) begin fails++; $display("FAIL ar_pre got v=%b %h want v=1 %h", out_tvalid, out_tdata, PT1); end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (out_tvalid !== 1'b0)  begin fails++; $display("FAIL ar_tvalid got %b want 0", out_tvalid); end
        tests++; if (out_tdata !== 32'h0)  begin fails++; $display("FAIL ar_tdata got %h want 0", out_tdata); end
        tests++; if (out_tuser !== 1'b1)   begin fails++; $display("FAIL ar_tuser got %b want 1", out_tuser); end
        tests++; if (out_tlast !== 1'b0)   begin fails++; $display("FAIL ar_tlast got %b want 0", out_tlast); end
        tests++; if (pkt_active !== 1'b0)  begin fails++; $display("FAIL ar_pkt_active got %b want 0", pkt_active); end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); #1;
            tests++; if (out_tvalid !== 1'b0 || out_tlast !== 1'b0) begin fails++; $display("FAIL ar_recover cycle %0d got v=%b l=%b want 0 0", c, out_tvalid, out_tlast); end
        end
        tests++; if (in_tready !== 1'b1) begin fails++; $display("FAIL ar_in_tready got %b want 1", in_tready); end
        @(negedge clk);
        in_tuser  = 1'b0;
        in_tdata  = 8'd3;
        in_tlast  = 1'b1;
        in_tvalid = 1'b1;
        @(negedge clk);
        in_tvalid = 1'b0;
        #1;
        tests++; if (out_tvalid !== 1'b1 || out_tdata !== PT2) begin fails++; $display("FAIL ar_restart got v=%b %h want v=1 %h", out_tvalid, out_tdata, PT2); end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_bpsk();
        test_qpsk();
        test_backpressure();
        test_underrun();
        test_pkt_boundary();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
